eth_stream_sched: RTL and testbench

//  Multi-stream scheduler placed in front of the 8-bit Ethernet packet generator.

---
 rtl/eth_sched_pkg.sv | 25 ++
 rtl/eth_prof_regfile.sv | 39 +++
 rtl/eth_stream_sched.sv | 172 +++++++++++++++++
 tb/tb_eth_stream_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sched_pkg.sv
// Shared types for the multi-stream Ethernet scheduler: the stream profile
// record handed to the packet generator and the scheduler state encoding.
package eth_sched_pkg;

  typedef struct packed {
    logic        valid;
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] etype;
    logic        len_mode;
    logic [15:0] len;
    logic [31:0] count;
    logic [15:0] ifg;
    logic [1:0]  payload;
  } eth_prof_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_NEXT = 3'd4
  } sched_state_e;

endpackage

// File: rtl/eth_prof_regfile.sv
// Profile storage: one register per stream slot, one write port, one
// asynchronous read port, and a per-slot "eligible to run" flag.
module eth_prof_regfile
  import eth_sched_pkg::*;
#(
  parameter int NUM_STREAMS = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_STREAMS)-1:0] wr_idx,
  input  eth_prof_t                      wr_data,
  input  logic [$clog2(NUM_STREAMS)-1:0] rd_idx,
  output eth_prof_t                      rd_data,
  output logic [NUM_STREAMS-1:0]         eligible
);

  eth_prof_t regs [NUM_STREAMS];

  // Slot registers; a write lands at the clock edge, so a same-cycle read sees the old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STREAMS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rd_data = regs[rd_idx];

  // A slot with a zero count would never see send_done, so it is not eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      eligible[i] = regs[i].valid && (regs[i].count != 32'd0);
    end
  end

endmodule

// File: rtl/eth_stream_sched.sv
// Round-robin sequencer of stream profiles into the 8-bit packet generator.
//
// Generator handshake: gen_enable is held high for the whole RUN state and the
// generator raises gen_send_done once its packet count is reached. send_done is
// only honoured after ARM_CYCLES clocks of RUN, so a level left high by the
// previous stream cannot end the new one early.
module eth_stream_sched
  import eth_sched_pkg::*;
#(
  parameter int NUM_STREAMS = 8,
  parameter int GAP_CYCLES  = 64,
  parameter int ARM_CYCLES  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           loop_en,
  input  logic                           pause,
  input  logic                           prof_wr_en,
  input  logic [$clog2(NUM_STREAMS)-1:0] prof_wr_idx,
  input  eth_prof_t                      prof_wr_data,
  output logic                           gen_enable,
  output logic                           gen_suspend,
  output logic                           gen_send_mode,
  output eth_prof_t                      gen_cfg,
  input  logic                           gen_send_done,
  output logic                           busy,
  output logic [$clog2(NUM_STREAMS)-1:0] cur_stream,
  output logic                           pass_done,
  output logic [31:0]                    streams_sent,
  output sched_state_e                   state_dbg
);

  localparam int IW = $clog2(NUM_STREAMS);
  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  sched_state_e       state, state_nxt;
  logic [IW-1:0]      cur_nxt;
  logic               pass_nxt;
  logic               load_cfg;
  logic               sent_inc;
  logic [AW-1:0]      arm_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               armed;
  logic               gap_done;
  eth_prof_t          rd_data;
  logic [NUM_STREAMS-1:0] eligible;
  logic               any_elig;
  logic [IW-1:0]      lowest_elig;
  logic               found_above;
  logic [IW-1:0]      next_above;

  eth_prof_regfile #(.NUM_STREAMS(NUM_STREAMS)) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (prof_wr_en),
    .wr_idx   (prof_wr_idx),
    .wr_data  (prof_wr_data),
    .rd_idx   (cur_stream),
    .rd_data  (rd_data),
    .eligible (eligible)
  );

  assign armed    = (arm_cnt == AW'(ARM_CYCLES));
  assign gap_done = (gap_cnt == GW'(GAP_CYCLES - 1));

  // Priority search: lowest eligible slot overall and lowest one above cur_stream.
  always_comb begin
    any_elig    = 1'b0;
    lowest_elig = '0;
    found_above = 1'b0;
    next_above  = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        any_elig    = 1'b1;
        lowest_elig = IW'(i);
        if (i > int'(cur_stream)) begin
          found_above = 1'b1;
          next_above  = IW'(i);
        end
      end
    end
  end

  // Next-state decode; stop overrides every other transition, including start.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_stream;
    pass_nxt  = 1'b0;
    load_cfg  = 1'b0;
    sent_inc  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && any_elig) begin
            state_nxt = ST_LOAD;
            cur_nxt   = lowest_elig;
          end
        end
        ST_LOAD: begin
          load_cfg  = 1'b1;
          state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (armed && gen_send_done) begin
            state_nxt = ST_GAP;
            sent_inc  = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_done) state_nxt = ST_NEXT;
        end
        ST_NEXT: begin
          if (found_above) begin
            state_nxt = ST_LOAD;
            cur_nxt   = next_above;
          end else begin
            pass_nxt = 1'b1;
            if (loop_en && any_elig) begin
              state_nxt = ST_LOAD;
              cur_nxt   = lowest_elig;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, slot index, latched profile, pass pulse and completed-stream counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cur_stream   <= '0;
      gen_cfg      <= '0;
      pass_done    <= 1'b0;
      streams_sent <= '0;
    end else begin
      state      <= state_nxt;
      cur_stream <= cur_nxt;
      pass_done  <= pass_nxt;
      if (load_cfg) gen_cfg <= rd_data;
      if (sent_inc) streams_sent <= streams_sent + 32'd1;
    end
  end

  // Arm counter runs from 0 on RUN entry; gap counter runs from 0 on GAP entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arm_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (state != ST_RUN) arm_cnt <= '0;
      else if (!armed)     arm_cnt <= arm_cnt + AW'(1);
      if (state != ST_GAP) gap_cnt <= '0;
      else                 gap_cnt <= gap_cnt + GW'(1);
    end
  end

  assign gen_enable    = (state == ST_RUN);
  assign gen_suspend   = pause;
  assign gen_send_mode = 1'b1;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_eth_stream_sched.sv
// Bench for eth_stream_sched: acts as the packet generator, keeps a slot-level
// model of the profiles, and predicts stream order, timing and counters.
module tb_eth_stream_sched;
  import eth_sched_pkg::*;

  localparam int NS  = 8;
  localparam int GAP = 5;
  localparam int ARM = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, stop = 1'b0, loop_en = 1'b0, pause = 1'b0;
  logic         prof_wr_en = 1'b0;
  logic [2:0]   prof_wr_idx = '0;
  eth_prof_t    prof_wr_data = '0;
  logic         gen_send_done = 1'b0;
  logic         gen_enable, gen_suspend, gen_send_mode, busy, pass_done;
  eth_prof_t    gen_cfg;
  logic [2:0]   cur_stream;
  logic [31:0]  streams_sent;
  sched_state_e state_dbg;

  eth_prof_t prof_m [NS];
  int checks = 0, errors = 0;
  int sent_m = 0, pass_m = 0, pass_seen = 0;

  eth_stream_sched #(.NUM_STREAMS(NS), .GAP_CYCLES(GAP), .ARM_CYCLES(ARM)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .pause(pause), .prof_wr_en(prof_wr_en), .prof_wr_idx(prof_wr_idx),
    .prof_wr_data(prof_wr_data), .gen_enable(gen_enable), .gen_suspend(gen_suspend),
    .gen_send_mode(gen_send_mode), .gen_cfg(gen_cfg), .gen_send_done(gen_send_done),
    .busy(busy), .cur_stream(cur_stream), .pass_done(pass_done),
    .streams_sent(streams_sent), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every clock advance goes through here so no pass_done pulse is missed.
  task automatic tick();
    @(posedge clock);
    #1;
    if (pass_done === 1'b1) pass_seen++;
  endtask

  function automatic int next_slot(input int after);
    for (int i = after + 1; i < NS; i++)
      if (prof_m[i].valid && prof_m[i].count != 32'd0) return i;
    return -1;
  endfunction

  function automatic eth_prof_t rand_prof();
    eth_prof_t p;
    p.valid    = ($urandom_range(0, 3) != 0);
    p.da       = {16'($urandom), $urandom};
    p.sa       = {16'($urandom), $urandom};
    p.etype    = 16'($urandom);
    p.len_mode = 1'($urandom);
    p.len      = 16'($urandom);
    p.count    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    p.ifg      = 16'($urandom);
    p.payload  = 2'($urandom);
    return p;
  endfunction

  function automatic eth_prof_t mk_prof(input logic v, input logic [31:0] c);
    eth_prof_t p;
    p = rand_prof();
    p.valid = v;
    p.count = c;
    return p;
  endfunction

  task automatic write_prof(input int idx, input eth_prof_t p);
    prof_wr_en   = 1'b1;
    prof_wr_idx  = 3'(idx);
    prof_wr_data = p;
    tick();
    prof_wr_en   = 1'b0;
    prof_m[idx]  = p;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) write_prof(i, '0);
  endtask

  // One stream: wait for enable, check slot/profile, play the generator with
  // send_done rising d clocks into RUN, then check run length and counter.
  task automatic run_one(input int slot, input int d, input int exp_wait,
                         input int rw_mode, input bit hold);
    int w, k, exp_len;
    eth_prof_t snap, np;
    w = 0;
    while (gen_enable !== 1'b1 && w < 300) begin
      tick();
      start = 1'b0;
      w++;
    end
    chk("enable_rise", gen_enable, 1'b1);
    chk("enable_latency", w, exp_wait);
    chk("cur_stream", cur_stream, slot);
    snap = prof_m[slot];
    chk("gen_cfg_load", gen_cfg, snap);
    k = 0;
    while (k < 300) begin
      if (k == d) gen_send_done = 1'b1;
      if (k == 1 && rw_mode != 0) begin
        np = prof_m[slot];
        if (rw_mode == 1) np.etype = np.etype + 16'd1;
        else              np.valid = 1'b0;
        prof_wr_en   = 1'b1;
        prof_wr_idx  = 3'(slot);
        prof_wr_data = np;
        prof_m[slot] = np;
      end
      tick();
      prof_wr_en = 1'b0;
      if (gen_enable !== 1'b1) break;
      k++;
    end
    if (!hold) gen_send_done = 1'b0;
    sent_m++;
    exp_len = ((d > ARM) ? d : ARM) + 1;
    chk("run_length", k + 1, exp_len);
    chk("streams_sent", streams_sent, sent_m);
    chk("gen_cfg_hold", gen_cfg, snap);
  endtask

  // A single pass (loop_en=0) over whatever the model says is eligible.
  task automatic run_pass(input int rw_slot, input int rw_mode);
    int s;
    bit first;
    s = next_slot(-1);
    start = 1'b1;
    if (s < 0) begin
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("idle_no_eligible_busy", busy, 1'b0);
      chk("idle_no_eligible_enable", gen_enable, 1'b0);
      return;
    end
    first = 1'b1;
    while (s >= 0) begin
      run_one(s, $urandom_range(0, 6), first ? 2 : GAP + 2, (s == rw_slot) ? rw_mode : 0, 1'b0);
      first = 1'b0;
      s = next_slot(s);
    end
    pass_m++;
    repeat (GAP + 1) tick();
    chk("pass_end_busy", busy, 1'b0);
    chk("pass_done_count", pass_seen, pass_m);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) prof_m[i] = '0;
    repeat (3) tick();
    chk("rst_enable", gen_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg", gen_cfg, '0);
    chk("rst_cur", cur_stream, 0);
    chk("rst_pass", pass_done, 1'b0);
    chk("rst_sent", streams_sent, 0);
    reset = 1'b1;
    tick();
    chk("send_mode", gen_send_mode, 1'b1);
    pause = 1'b1; #1;
    chk("suspend_hi", gen_suspend, 1'b1);
    pause = 1'b0; #1;
    chk("suspend_lo", gen_suspend, 1'b0);

    // Two valid slots, single pass.
    write_prof(0, mk_prof(1'b1, 32'd3));
    write_prof(2, mk_prof(1'b1, 32'd5));
    run_pass(-1, 0);
    chk("two_streams_sent", streams_sent, 2);

    // Zero-count slot skipped.
    write_prof(0, mk_prof(1'b0, 32'd3));
    write_prof(2, mk_prof(1'b0, 32'd5));
    write_prof(1, mk_prof(1'b1, 32'd0));
    write_prof(3, mk_prof(1'b1, 32'd2));
    run_pass(-1, 0);

    // Rewrite active slot during RUN, then clear its valid during RUN.
    run_pass(3, 1);
    run_pass(3, 2);
    run_pass(-1, 0);

    // Randomized profile tables.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) write_prof(i, rand_prof());
      run_pass(-1, 0);
    end

    // Loop mode with one slot, then stop mid-RUN.
    clear_all();
    write_prof(5, mk_prof(1'b1, 32'd1));
    loop_en = 1'b1;
    start = 1'b1;
    run_one(5, $urandom_range(0, 6), 2, 0, 1'b0);
    pass_m++;
    run_one(5, $urandom_range(0, 6), GAP + 2, 0, 1'b0);
    pass_m++;
    for (int w = 0; w < 300 && gen_enable !== 1'b1; w++) tick();
    chk("loop_third_enable", gen_enable, 1'b1);
    chk("loop_pass_count", pass_seen, pass_m);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 1'b0;
    chk("stop_enable", gen_enable, 1'b0);
    chk("stop_busy", busy, 1'b0);
    chk("stop_sent", streams_sent, sent_m);

    // send_done left high across the gap must not end the next stream early.
    clear_all();
    write_prof(4, mk_prof(1'b1, 32'd7));
    write_prof(6, mk_prof(1'b1, 32'd9));
    start = 1'b1;
    run_one(4, 1, 2, 0, 1'b1);
    run_one(6, 0, GAP + 2, 0, 1'b0);
    pass_m++;
    repeat (GAP + 1) tick();
    chk("held_done_busy", busy, 1'b0);

    // Asynchronous reset in the middle of GAP.
    write_prof(2, mk_prof(1'b1, 32'd4));
    start = 1'b1;
    run_one(2, 0, 2, 0, 1'b0);
    tick();
    tick();
    chk("gap_busy_before_reset", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_enable", gen_enable, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cfg", gen_cfg, '0);
    chk("arst_cur", cur_stream, 0);
    chk("arst_sent", streams_sent, 0);
    chk("arst_pass", pass_done, 1'b0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < NS; i++) prof_m[i] = '0;
    sent_m = 0;
    run_pass(-1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
